// File: rtl/display_pkg.sv
// Shared constants for the 4-digit seven-segment scan controller:
// inactive bus levels, scan FSM state encoding and the hex segment table.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0]      SEG_OFF   = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Active-low {g,f,e,d,c,b,a}; entry k decodes hex digit k (F down to 0).
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_to_seven_segment.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seven_segment
  import display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = SEG_TABLE[nibble];

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit seven-segment scanner with a frame-synchronous value handshake.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [SEG_W-1:0]      display,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  frame_done
);

  localparam int unsigned CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DRIVE_PRE  = CNT_W'(CLK_DIV - 2);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t           state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [1:0]            idx, idx_nxt;
  logic [15:0]           shadow, pending;
  logic                  boundary_c;
  logic                  frame_pre_c;
  logic                  accept_c;
  logic                  lz_blank_c;
  logic [3:0]            nibble_c;
  logic [SEG_W-1:0]      seg_c;
  logic [SEG_W-1:0]      display_nxt;
  logic [NUM_DIGITS-1:0] anode_nxt;

  // Dwell counter and digit sequencing.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CNT_W'(1);
    idx_nxt    = idx;
    boundary_c = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_DRIVE;
          cnt_nxt   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          state_nxt  = ST_BLANK;
          cnt_nxt    = '0;
          idx_nxt    = idx + 2'd1;
          boundary_c = (idx == 2'd3);
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

  // frame_done is registered, so it is armed one cycle before the boundary cycle.
  assign frame_pre_c = (state == ST_DRIVE) && (idx == 2'd3) && (cnt == DRIVE_PRE);
  assign accept_c    = value_valid && value_ready;
  assign nibble_c    = shadow[{idx_nxt, 2'b00} +: 4];

  hex_to_seven_segment u_dec (
    .nibble (nibble_c),
    .seg_c  (seg_c)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit 0 is never blanked so an all-zero value still shows "0".
  always_comb begin
    case (idx_nxt)
      2'd3:    lz_blank_c = (shadow[15:12] == 4'h0);
      2'd2:    lz_blank_c = (shadow[15:8] == 8'h00);
      2'd1:    lz_blank_c = (shadow[15:4] == 12'h000);
      default: lz_blank_c = 1'b0;
    endcase
  end
`else
  assign lz_blank_c = 1'b0;
`endif

  // Outputs are computed from the next state so they are valid in each state's first cycle.
  always_comb begin
    anode_nxt   = ANODE_OFF;
    display_nxt = SEG_OFF;
    if (state_nxt == ST_DRIVE) begin
      anode_nxt = ANODE_OFF ^ (4'b0001 << idx_nxt);
      if (!lz_blank_c) begin
        display_nxt = seg_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      pending     <= '0;
      value_ready <= 1'b1;
      frame_done  <= 1'b0;
      anode       <= ANODE_OFF;
      display     <= SEG_OFF;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      frame_done <= frame_pre_c;
      anode      <= anode_nxt;
      display    <= display_nxt;
      // Shadow only moves at the frame boundary so a frame never mixes two values.
      if (boundary_c) begin
        if (accept_c) begin
          shadow <= value_in;
        end else if (!value_ready) begin
          shadow <= pending;
        end
        value_ready <= 1'b1;
      end else if (accept_c) begin
        pending     <= value_in;
        value_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (CLK_DIV=4, BLANK_CYCLES=2, 20 ns clock).
module tb_display_scan_controller;

  localparam int CD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = CD + BC;
  localparam int FRAME = 4 * SLOT;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0][6:0] seg;   // seg[d] = expected pattern on digit d
  } vec_t;

  localparam int NV = 8;

  logic        clk         = 1'b0;
  logic        rst         = 1'b0;
  logic [15:0] value_in    = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        frame_done;
  logic [6:0]  display;
  logic [3:0]  anode;

  int total = 0;
  int bad   = 0;

  // Reference model state: cycles since reset release plus the transfer registers.
  int          m_c      = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pend   = '0;
  logic        m_full   = 1'b0;
  logic        chk_en   = 1'b0;

  logic [3:0]  e_anode;
  logic [6:0]  e_disp;
  logic        e_rdy, e_fd;
  int          e_pos, e_slot;

  vec_t vecs [NV];

  display_scan_controller #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .display     (display),
    .anode       (anode),
    .frame_done  (frame_done)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] digit_seg(input logic [15:0] v, input int d);
    logic [15:0] above;
    above = v >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && above == 16'h0) return 7'h7F;
`endif
    return seg_of(above[3:0]);
  endfunction

  // Transfer rule: accept into pending, or straight to shadow on the boundary cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_c      <= 0;
      m_shadow <= '0;
      m_pend   <= '0;
      m_full   <= 1'b0;
    end else begin
      m_c <= m_c + 1;
      if (m_c % FRAME == FRAME - 1) begin
        if (value_valid && !m_full) m_shadow <= value_in;
        else if (m_full)            m_shadow <= m_pend;
        m_full <= 1'b0;
      end else if (value_valid && !m_full) begin
        m_pend <= value_in;
        m_full <= 1'b1;
      end
    end
  end

  // Every cycle: scan position derived arithmetically from the cycle count.
  always @(negedge clk) begin
    if (chk_en) begin
      e_anode = 4'hF;
      e_disp  = 7'h7F;
      e_rdy   = 1'b1;
      e_fd    = 1'b0;
      if (rst) begin
        e_pos  = m_c % FRAME;
        e_slot = e_pos / SLOT;
        if (e_pos % SLOT >= BC) begin
          e_anode = 4'hF ^ (4'h1 << e_slot);
          e_disp  = digit_seg(m_shadow, e_slot);
        end
        e_rdy = !m_full;
        e_fd  = (e_pos == FRAME - 1);
      end
      check("model_anode", 16'(anode), 16'(e_anode));
      check("model_display", 16'(display), 16'(e_disp));
      check("model_ready", 16'(value_ready), 16'(e_rdy));
      check("model_frame_done", 16'(frame_done), 16'(e_fd));
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!value_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ready_timeout", 16'(value_ready), 16'd1);
  endtask

  task automatic wait_fd();
    int k;
    k = 0;
    while (!frame_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("frame_done_timeout", 16'(frame_done), 16'd1);
  endtask

  // One-cycle offer; ready afterwards stays high only if the accept hit the boundary.
  task automatic load(input logic [15:0] v);
    logic fd_at_offer;
    wait_ready();
    fd_at_offer = frame_done;
    value_valid = 1'b1;
    value_in    = v;
    @(negedge clk);
    value_valid = 1'b0;
    check("ready_after_accept", 16'(value_ready), 16'(fd_at_offer));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic prev_fd;
    logic rdy_seen;
    int   k;

    vecs[0] = '{16'h12F0, {7'h79, 7'h24, 7'h0E, 7'h40}};
    vecs[1] = '{16'h0005, {LZ, LZ, LZ, 7'h12}};
    vecs[2] = '{16'hA5C3, {7'h08, 7'h12, 7'h46, 7'h30}};
    vecs[3] = '{16'h0080, {LZ, LZ, 7'h00, 7'h40}};
    vecs[4] = '{16'h0000, {LZ, LZ, LZ, 7'h40}};
    vecs[5] = '{16'hFFFF, {7'h0E, 7'h0E, 7'h0E, 7'h0E}};
    vecs[6] = '{16'h7E69, {7'h78, 7'h06, 7'h02, 7'h10}};
    vecs[7] = '{16'h0300, {LZ, 7'h30, 7'h40, 7'h40}};

    #15;
    check("reset_anode", 16'(anode), 16'hF);
    check("reset_display", 16'(display), 16'h7F);
    check("reset_ready", 16'(value_ready), 16'd1);
    check("reset_frame_done", 16'(frame_done), 16'd0);
    #5;
    rst    = 1'b1;
    chk_en = 1'b1;

    // Table: load, wait for the frame that shows it, then check its whole scan.
    for (int r = 0; r < NV; r++) begin
      load(vecs[r].value);
      wait_fd();
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        if (i % SLOT < BC) begin
          check("scan_blank_anode", 16'(anode), 16'hF);
          check("scan_blank_display", 16'(display), 16'h7F);
        end else begin
          check("scan_anode", 16'(anode), 16'(4'hF ^ (4'h1 << (i / SLOT))));
          check("scan_display", 16'(display), 16'(vecs[r].seg[i / SLOT]));
        end
        check("scan_frame_done", 16'(frame_done), 16'(i == FRAME - 1));
      end
    end

    // Back-to-back offers: the second is held off until one cycle after frame_done.
    wait_fd();
    repeat (2) @(negedge clk);
    value_valid = 1'b1;
    value_in    = 16'hAAAA;
    @(negedge clk);
    value_in = 16'h5555;
    prev_fd  = frame_done;
    k        = 0;
    while (!value_ready && k < 100) begin
      prev_fd = frame_done;
      @(negedge clk);
      k++;
    end
    check("b2b_ready_returned", 16'(value_ready), 16'd1);
    check("b2b_ready_after_fd", 16'(prev_fd), 16'd1);
    @(negedge clk);
    value_valid = 1'b0;

    // Reset mid-DRIVE on digit 2 with a value pending.
    wait_fd();
    load(16'hBEEF);
    k = 0;
    while (anode != 4'b1011 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("digit2_reached", 16'(anode), 16'hB);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_anode", 16'(anode), 16'hF);
    check("midrst_display", 16'(display), 16'h7F);
    check("midrst_ready", 16'(value_ready), 16'd1);
    check("midrst_frame_done", 16'(frame_done), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    while (anode == 4'hF && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("restart_anode", 16'(anode), 16'hE);
    check("restart_display", 16'(display), 16'h40);
    wait_fd();
    k = 0;
    while (anode != 4'b1101 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("pending_discarded", 16'(display), 16'(LZ));

    // Random producer that holds its offer until accepted.
    rdy_seen = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!value_valid || rdy_seen) begin
        value_valid = ($urandom_range(0, 2) == 0);
        value_in    = 16'($urandom);
      end
      rdy_seen = value_ready;
      @(negedge clk);
    end
    value_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter CLK_DIV, default 50000: clock cycles each digit is driven (DRIVE dwell); legal >= 2.
REQ-002 Parameter BLANK_CYCLES, default 8: clock cycles all digits are off between digits; legal >= 1.
REQ-003 Port clk, input, 1: single clock; all state SHALL be on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port value_in, input, 16: four hex nibbles; nibble k drives digit k, where digit 0 = value_in[3:0].
REQ-006 Port value_valid, input, 1: value_in offered.
REQ-007 Port value_ready, output, 1: controller can accept a value.
REQ-008 Port display, output, 7: shared segment bus, active-low, {g,f,e,d,c,b,a}.
REQ-009 Port anode, output, 4: digit enables, active-low, one-hot-low while driving.
REQ-010 Port frame_done, output, 1: one-cycle pulse at the end of the digit-3 dwell.

Function
REQ-011 FSM states SHALL be BLANK and DRIVE, with a dwell counter and a 2-bit digit_idx.
- BLANK: anode=4'b1111, display=7'b1111111; after BLANK_CYCLES cycles go to DRIVE and clear the counter.
- DRIVE: anode[digit_idx]=0, display=decode(shadow nibble digit_idx); after CLK_DIV cycles go to BLANK and advance digit_idx (wraps 3->0).
REQ-012 anode and display SHALL be registered and valid in the first cycle of each state; frame period = 4*(CLK_DIV+BLANK_CYCLES) cycles.
REQ-013 Hex decode examples: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 5=7'b0010010, 8=7'b0000000, F=7'b0001110.
REQ-014 Transfer rule: an accept occurs when value_valid && value_ready.
- The accepted value goes into the pending register.
- value_ready SHALL drop the next cycle.
REQ-015 Frame boundary (the DRIVE digit 3 -> BLANK transition cycle):
- pending is copied to shadow;
- frame_done pulses high for that one cycle;
- value_ready rises the next cycle.
REQ-016 If an accept coincides with a frame boundary, value_in SHALL go directly to shadow and value_ready SHALL stay high.
REQ-017 value_valid while value_ready=0 SHALL be ignored; the producer holds the value.
REQ-018 Shadow SHALL change only at frame boundaries, so no frame ever shows mixed old and new digits.

Reset
REQ-019 While rst=0, outputs SHALL be:
- anode=4'b1111, display=7'b1111111;
- value_ready=1, frame_done=0;
- state=BLANK, digit_idx=0, counter=0;
- shadow=16'h0000, pending cleared.
REQ-020 Reset asserted mid-operation SHALL blank outputs immediately, discard the pending value, and restart at BLANK digit 0 on release.

Configuration
REQ-021 Macro LEADING_ZERO_BLANK_EN, when defined:
- digits above the most significant nonzero nibble SHALL output display=7'b1111111 while their anode is still scanned;
- digit 0 SHALL always be decoded.
REQ-022 Without LEADING_ZERO_BLANK_EN, all four digits SHALL be decoded normally.

Structure
REQ-023 Shared package display_pkg SHALL hold SEG_OFF=7'b1111111, ANODE_OFF=4'b1111, the FSM state encoding, and the 16-entry hex segment table.
REQ-024 The decoder SHALL be the sub-module hex_to_seven_segment: combinational, 4-bit in, 7-bit active-low out, built on the package table.

Verification (bench parameters CLK_DIV=4, BLANK_CYCLES=2, 20 ns clock)
REQ-025 Reset: rst=0 for 20 ns -> anode=4'b1111, display=7'b1111111, value_ready=1, frame_done=0.
REQ-026 Load 16'h12F0 after reset -> after the first frame_done, scan SHALL show:
- anode 4'b1110 / display 7'b1000000;
- anode 4'b1101 / 7'b0001110;
- anode 4'b1011 / 7'b0100100;
- anode 4'b0111 / 7'b1111001;
- frame_done every 24 cycles.
REQ-027 Blanking: anode=4'b1111 for exactly 2 cycles between each 4-cycle DRIVE; no overlapping anodes ever.
REQ-028 Handshake with two back-to-back valids (16'hAAAA then 16'h5555):
- second valid held off until value_ready returns, 1 cycle after frame_done;
- shadow SHALL never mix the two values.
REQ-029 Reset mid-DRIVE on digit 2 -> outputs off in the same timestep; after release, scan restarts at digit 0 with shadow 16'h0000.
REQ-030 Load 16'h0005:
- with LEADING_ZERO_BLANK_EN: digits 3..1 display 7'b1111111, digit 0 shows 7'b0010010;
- without it: digits 3..1 show 7'b1000000.
